// File: rtl/mem2_port_arbiter_if.sv
// Bundle between the two memory-port requesters, the memory, and the port-2 arbiter.
// master = requester/memory side, slave = arbiter side.
interface mem2_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_req;
  logic          r0_we;
  logic [1:0]    r0_size;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;

  logic          r1_req;
  logic          r1_we;
  logic [1:0]    r1_size;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_rden;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport master (
    output r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid,
    output r1_req, r1_we, r1_size, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid,
    input  rdata,
    input  mem_rden, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  r0_req, r0_we, r0_size, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid,
    input  r1_req, r1_we, r1_size, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid,
    output rdata,
    output mem_rden, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/mem2_port_arbiter.sv
// Round-robin arbiter for OTTER data-memory port 2 (CPU vs DMA/debug), one transaction in flight.
// Grants combinationally in IDLE; reads hold the port for RD_LAT cycles until the data cycle.
module mem2_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               RST,
  mem2_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;

  logic          grant;
  logic          sel;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          data_cyc;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    sel       = 1'b0;
    sel_we    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (bus.r0_req && bus.r1_req) begin
      sel = ~last_gnt_q;
    end else begin
      sel = bus.r1_req;
    end
    if (sel) begin
      sel_we    = bus.r1_we;
      sel_size  = bus.r1_size;
      sel_addr  = bus.r1_addr;
      sel_wdata = bus.r1_wdata;
    end else begin
      sel_we    = bus.r0_we;
      sel_size  = bus.r0_size;
      sel_addr  = bus.r0_addr;
      sel_wdata = bus.r0_wdata;
    end
    grant    = !RST && (state_q == IDLE) && (bus.r0_req || bus.r1_req);
    data_cyc = !RST && (state_q == RD_WAIT) && (rd_cnt_q == 3'd1);
  end

  always_comb begin
    bus.r0_gnt    = grant && !sel;
    bus.r1_gnt    = grant && sel;
    bus.mem_we    = grant && sel_we;
    bus.mem_rden  = grant && !sel_we;
    bus.mem_size  = grant ? sel_size  : 2'b00;
    bus.mem_addr  = grant ? sel_addr  : '0;
    bus.mem_wdata = grant ? sel_wdata : '0;
    bus.r0_rvalid = data_cyc && !owner_q;
    bus.r1_rvalid = data_cyc && owner_q;
    bus.busy      = !RST && (state_q == RD_WAIT);
    bus.rdata     = bus.mem_rdata;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    rd_cnt_d   = rd_cnt_q;
    if (grant) begin
      last_gnt_d = sel;
      if (!sel_we) begin
        owner_d  = sel;
        rd_cnt_d = RD_LAT_C;
        state_d  = RD_WAIT;
      end
    end
    if (state_q == RD_WAIT) begin
      rd_cnt_d = rd_cnt_q - 3'd1;
      if (rd_cnt_q == 3'd1) begin
        state_d = IDLE;
      end
    end
  end

  // last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      rd_cnt_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem2_port_arbiter.sv
// Bench for mem2_port_arbiter: directed scenarios plus randomized traffic on RD_LAT=1 and RD_LAT=3 instances.
module tb_mem2_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index d: 0 -> RD_LAT=1 instance, 1 -> RD_LAT=3 instance.
  logic        rst [2];
  logic        rq  [2][2];
  logic        wr  [2][2];
  logic [1:0]  sz  [2][2];
  logic [31:0] ad  [2][2];
  logic [31:0] wd  [2][2];
  logic [31:0] mrd [2];

  wire        gn     [2][2];
  wire        rv     [2][2];
  wire        rden   [2];
  wire        mwe    [2];
  wire        busy_w [2];
  wire [1:0]  msize  [2];
  wire [31:0] maddr  [2];
  wire [31:0] mwdata [2];
  wire [31:0] rdat   [2];

  int n_tests = 0;
  int n_fail  = 0;

  mem2_port_arbiter_if #(.AW(32), .DW(32)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus[g].r0_req    = rq[g][0];
    assign bus[g].r0_we     = wr[g][0];
    assign bus[g].r0_size   = sz[g][0];
    assign bus[g].r0_addr   = ad[g][0];
    assign bus[g].r0_wdata  = wd[g][0];
    assign bus[g].r1_req    = rq[g][1];
    assign bus[g].r1_we     = wr[g][1];
    assign bus[g].r1_size   = sz[g][1];
    assign bus[g].r1_addr   = ad[g][1];
    assign bus[g].r1_wdata  = wd[g][1];
    assign bus[g].mem_rdata = mrd[g];
    assign gn[g][0]  = bus[g].r0_gnt;
    assign gn[g][1]  = bus[g].r1_gnt;
    assign rv[g][0]  = bus[g].r0_rvalid;
    assign rv[g][1]  = bus[g].r1_rvalid;
    assign rden[g]   = bus[g].mem_rden;
    assign mwe[g]    = bus[g].mem_we;
    assign busy_w[g] = bus[g].busy;
    assign msize[g]  = bus[g].mem_size;
    assign maddr[g]  = bus[g].mem_addr;
    assign mwdata[g] = bus[g].mem_wdata;
    assign rdat[g]   = bus[g].rdata;

    mem2_port_arbiter #(.AW(32), .DW(32), .RD_LAT(g == 0 ? 1 : 3)) dut (
      .clk (clk),
      .RST (rst[g]),
      .bus (bus[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag order: {r0_gnt, r1_gnt, mem_rden, mem_we, busy, r0_rvalid, r1_rvalid}
  function automatic logic [6:0] flags(input int d);
    return {gn[d][0], gn[d][1], rden[d], mwe[d], busy_w[d], rv[d][0], rv[d][1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input int i, input logic r, input logic w,
                         input logic [1:0] s, input logic [31:0] a, input logic [31:0] dat);
    rq[d][i] = r;
    wr[d][i] = w;
    sz[d][i] = s;
    ad[d][i] = a;
    wd[d][i] = dat;
  endtask

  task automatic clear_reqs(input int d);
    set_req(d, 0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(d, 1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // Leaves the caller at cycle 0 after reset with RST low.
  task automatic do_reset(input int d);
    clear_reqs(d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
  endtask

  // Randomized traffic checked against cycle-numbered port-occupancy rules.
  task automatic rand_run(input int d, input int lat, input int n);
    int          rd_cyc;
    int          rd_own;
    int          last;
    int          w;
    logic        g_prev [2];
    logic        rst_now;
    logic [6:0]  ef;
    logic [65:0] em;
    do_reset(d);
    rd_cyc = -1000;
    rd_own = 0;
    last   = 1;
    g_prev[0] = 1'b0;
    g_prev[1] = 1'b0;
    for (int cyc = 0; cyc < n; cyc++) begin
      rst_now = ($urandom_range(0, 63) == 0);
      rst[d]  = rst_now;
      for (int i = 0; i < 2; i++) begin
        if (g_prev[i]) rq[d][i] = 1'b0;
        if (!rq[d][i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(d, i, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    $urandom, $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          rq[d][i] = 1'b0;
        end
      end
      mrd[d] = $urandom;
      #2;
      ef = '0;
      em = '0;
      g_prev[0] = 1'b0;
      g_prev[1] = 1'b0;
      if (rst_now) begin
        last   = 1;
        rd_cyc = -1000;
      end else if (cyc > rd_cyc && cyc <= rd_cyc + lat) begin
        ef[2] = 1'b1;
        if (cyc == rd_cyc + lat) ef[rd_own == 0 ? 1 : 0] = 1'b1;
      end else if (rq[d][0] || rq[d][1]) begin
        if (rq[d][0] && rq[d][1]) w = 1 - last;
        else                      w = rq[d][1] ? 1 : 0;
        g_prev[w] = 1'b1;
        ef[w == 0 ? 6 : 5] = 1'b1;
        if (wr[d][w]) ef[3] = 1'b1;
        else          ef[4] = 1'b1;
        em   = {sz[d][w], ad[d][w], wd[d][w]};
        last = w;
        if (!wr[d][w]) begin
          rd_cyc = cyc;
          rd_own = w;
        end
      end
      chk($sformatf("rnd%0d_flags_c%0d", d, cyc), 128'(flags(d)), 128'(ef));
      chk($sformatf("rnd%0d_mem_c%0d", d, cyc), 128'({msize[d], maddr[d], mwdata[d]}), 128'(em));
      chk($sformatf("rnd%0d_rdata_c%0d", d, cyc), 128'(rdat[d]), 128'(mrd[d]));
      tick();
    end
    rst[d] = 1'b0;
    clear_reqs(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      mrd[d] = 32'h0;
      clear_reqs(d);
    end

    // Reset state: a pending request during RST gets nothing.
    set_req(0, 0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    mrd[0] = 32'hDEADBEEF;
    tick();
    #2;
    chk("rst_flags", 128'(flags(0)), 128'(7'b0000000));
    chk("rst_addr", 128'(maddr[0]), 128'(32'h0));
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // RD_LAT=1 read of 0x100.
    #2;
    chk("rd1_c0_flags", 128'(flags(0)), 128'(7'b1010000));
    chk("rd1_c0_addr", 128'(maddr[0]), 128'(32'h100));
    tick();
    rq[0][0] = 1'b0;
    #2;
    chk("rd1_c1_flags", 128'(flags(0)), 128'(7'b0000110));
    chk("rd1_c1_rdata", 128'(rdat[0]), 128'(32'hDEADBEEF));
    tick();
    #2;
    chk("rd1_c2_flags", 128'(flags(0)), 128'(7'b0000000));

    // Both write continuously: strict alternation starting with r0.
    do_reset(0);
    set_req(0, 0, 1'b1, 1'b1, 2'b10, 32'h10, 32'hA0A00001);
    set_req(0, 1, 1'b1, 1'b1, 2'b10, 32'h20, 32'hB1B10002);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("alt_flags_%0d", k), 128'(flags(0)),
          128'((k % 2 == 0) ? 7'b1001000 : 7'b0101000));
      chk($sformatf("alt_wdata_%0d", k), 128'(mwdata[0]),
          128'((k % 2 == 0) ? 32'hA0A00001 : 32'hB1B10002));
      tick();
    end
    clear_reqs(0);

    // Half-word write passes size/address through, no rvalid.
    do_reset(0);
    set_req(0, 0, 1'b1, 1'b1, 2'b01, 32'h42, 32'h1234);
    #2;
    chk("sz_flags", 128'(flags(0)), 128'(7'b1001000));
    chk("sz_mem", 128'({msize[0], maddr[0]}), 128'({2'b01, 32'h42}));
    tick();
    rq[0][0] = 1'b0;
    #2;
    chk("sz_after", 128'(flags(0)), 128'(7'b0000000));

    // RD_LAT=3: r1 read, r0 write waits for the port.
    do_reset(1);
    set_req(1, 1, 1'b1, 1'b0, 2'b10, 32'h2000, 32'h0);
    #2;
    chk("lat3_c0_flags", 128'(flags(1)), 128'(7'b0110000));
    chk("lat3_c0_addr", 128'(maddr[1]), 128'(32'h2000));
    tick();
    rq[1][1] = 1'b0;
    set_req(1, 0, 1'b1, 1'b1, 2'b10, 32'h30, 32'h55);
    for (int k = 1; k <= 3; k++) begin
      #2;
      chk($sformatf("lat3_c%0d_flags", k), 128'(flags(1)),
          128'(k == 3 ? 7'b0000101 : 7'b0000100));
      tick();
    end
    #2;
    chk("lat3_c4_flags", 128'(flags(1)), 128'(7'b1001000));
    chk("lat3_c4_wdata", 128'(mwdata[1]), 128'(32'h55));
    tick();
    clear_reqs(1);

    // Reset mid-read drops the read; next request granted right after reset.
    do_reset(1);
    set_req(1, 1, 1'b1, 1'b0, 2'b10, 32'h2000, 32'h0);
    #2;
    chk("rstrd_c0", 128'(flags(1)), 128'(7'b0110000));
    tick();
    rq[1][1] = 1'b0;
    #2;
    chk("rstrd_c1", 128'(flags(1)), 128'(7'b0000100));
    tick();
    rst[1] = 1'b1;
    set_req(1, 0, 1'b1, 1'b0, 2'b10, 32'h44, 32'h0);
    #2;
    chk("rstrd_c2", 128'(flags(1)), 128'(7'b0000000));
    tick();
    rst[1] = 1'b0;
    #2;
    chk("rstrd_c3", 128'(flags(1)), 128'(7'b1010000));
    tick();
    clear_reqs(1);

    // r1 requests during r0's read then withdraws: no grant, round-robin unchanged.
    do_reset(1);
    set_req(1, 0, 1'b1, 1'b0, 2'b10, 32'h80, 32'h0);
    #2;
    chk("wd_c0", 128'(flags(1)), 128'(7'b1010000));
    tick();
    rq[1][0] = 1'b0;
    set_req(1, 1, 1'b1, 1'b0, 2'b10, 32'h90, 32'h0);
    #2;
    chk("wd_c1", 128'(flags(1)), 128'(7'b0000100));
    tick();
    rq[1][1] = 1'b0;
    #2;
    chk("wd_c2", 128'(flags(1)), 128'(7'b0000100));
    tick();
    #2;
    chk("wd_c3", 128'(flags(1)), 128'(7'b0000110));
    tick();
    set_req(1, 0, 1'b1, 1'b1, 2'b10, 32'hA0, 32'h1);
    set_req(1, 1, 1'b1, 1'b1, 2'b10, 32'hB0, 32'h2);
    #2;
    chk("wd_c4_tie", 128'(flags(1)), 128'(7'b0101000));
    tick();
    clear_reqs(1);

    rand_run(0, 1, 400);
    rand_run(1, 3, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem2_port_arbiter.md
Name: mem2_port_arbiter

Overview:
- Two-requester arbiter for the OTTER data-memory port 2.
- Requester 0 is the CPU data path (load/store from the control FSM); requester 1 is a DMA/debug master.
- Grants the single memory port round-robin, drives the memory controls, and sequences the fixed-latency read return.
- Supports one outstanding transaction at a time.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the mem_rden cycle to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock.
- RST  in  1  reset: synchronous, active-high.
- r0_req  in  1  requester 0 request; held until r0_gnt.
- r0_we  in  1  requester 0 write (1) / read (0).
- r0_size  in  2  requester 0 access size (00 byte, 01 half, 10 word); passed through.
- r0_addr  in  AW  requester 0 address.
- r0_wdata  in  DW  requester 0 write data.
- r0_gnt  out  1  requester 0 grant pulse.
- r0_rvalid  out  1  requester 0 read data valid pulse.
- r1_req, r1_we, r1_size, r1_addr, r1_wdata, r1_gnt, r1_rvalid: same as requester 0, for requester 1.
- rdata  out  DW  shared read data, valid only when rX_rvalid=1.
- mem_rden  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_size  out  2  memory access size.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high while a read is outstanding.

Behaviour:
- States: IDLE, RD_WAIT. Registers: state, owner (1 bit), last_gnt (1 bit), rd_cnt (3 bits).
- Reset (RST=1 at posedge):
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie), rd_cnt=0, owner=0.
  - During any cycle with RST=1, all outputs are forced to 0: gnt, rvalid, mem_rden, mem_we, busy.
- IDLE, no req: all gnt=0, mem_rden=mem_we=0. mem_addr, mem_wdata and mem_size are driven 0.
- IDLE, exactly one req: grant that requester in the same cycle (combinational rX_gnt=1). mem_* are driven from that requester's inputs in the same cycle.
- IDLE, both req: grant requester != last_gnt. The loser sees gnt=0 and must hold its request stable.
- On any grant: last_gnt <= granted index at the posedge.
- Granted write:
  - mem_we=1 for that single cycle; the write is complete.
  - Stay in IDLE; a new grant is possible the next cycle (one write per cycle sustained).
- Granted read:
  - mem_rden=1 for that single cycle.
  - owner <= index, rd_cnt <= RD_LAT, state <= RD_WAIT.
- RD_WAIT:
  - busy=1, no grants, mem_rden=mem_we=0; decrement rd_cnt each cycle.
  - The cycle in which rd_cnt==1 is the data cycle: r{owner}_rvalid=1, rdata=mem_rdata, state <= IDLE.
  - Read-to-rvalid latency is exactly RD_LAT cycles. Next grant is no earlier than RD_LAT+1 cycles after the read grant.
- rdata: combinational pass-through of mem_rdata at all times; meaningful only when rvalid=1.
- Request withdrawal: a requester dropping req before being granted receives no grant and loses nothing; arbitration state is unchanged.
- Requests during RD_WAIT are ignored until IDLE. Round-robin then applies against last_gnt.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1... Maximum wait is one transaction.
- Reset mid-read: the outstanding read is dropped, no rvalid is issued, state=IDLE. Both requesters must re-request.
- Only one of r0_gnt/r1_gnt is ever 1, and only one of mem_rden/mem_we is ever 1.

Test Plan:
- Reset then r0 read addr=0x100, mem_rdata=0xDEADBEEF, RD_LAT=1 -> r0_gnt and mem_rden in cycle 0 with mem_addr=0x100; r0_rvalid=1, rdata=0xDEADBEEF in cycle 1; busy=1 only in cycle 1.
- After reset, r0 and r1 assert write simultaneously and hold -> gnt order r0,r1,r0,r1 on consecutive cycles; mem_we=1 every cycle; mem_wdata tracks the granted requester.
- RD_LAT=3, r1 read of 0x2000 while r0 requests a write from cycle 1 -> r1_rvalid in cycle 3; r0_gnt not before cycle 4; mem_we=0 in cycles 1-3.
- r1 read granted at cycle 0 (RD_LAT=3), RST=1 in cycle 2 -> no r1_rvalid at any cycle; busy=0 from cycle 2; the next r0 request is granted immediately after RST deasserts.
- r1 asserts req in cycle 0 while r0 holds the port in RD_WAIT, then withdraws in cycle 1 -> r1_gnt never asserted; last_gnt unchanged.
- r0 write with r0_size=01, addr=0x42 -> mem_size=01, mem_addr=0x42 in the grant cycle; r0_rvalid stays 0.
